// File: rtl/alsu_pkg.sv
// alsu_pkg: shared definitions for the ALSU logic issue stage.
//   - logic-unit select encodings
//   - default operand/select widths
//   - command record {a, b, sel} as carried through the issue FIFO
//   - output-slot state encoding
package alsu_pkg;

  localparam int ALSU_DATA_W = 4;
  localparam int ALSU_SEL_W  = 2;

  localparam logic [ALSU_SEL_W-1:0] SEL_AND  = 2'b00;
  localparam logic [ALSU_SEL_W-1:0] SEL_OR   = 2'b01;
  localparam logic [ALSU_SEL_W-1:0] SEL_XOR  = 2'b10;
  localparam logic [ALSU_SEL_W-1:0] SEL_XNOR = 2'b11;

  typedef struct packed {
    logic [ALSU_DATA_W-1:0] a;
    logic [ALSU_DATA_W-1:0] b;
    logic [ALSU_SEL_W-1:0]  sel;
  } cmd_t;

  typedef enum logic {
    SLOT_IDLE = 1'b0,
    SLOT_HOLD = 1'b1
  } slot_state_t;

endpackage

// File: rtl/alsu_cmd_fifo.sv
// alsu_cmd_fifo: parameterised synchronous FIFO for issue commands.
//   clk, rst   : clock, synchronous active-high reset (clears pointers/count)
//   push       : write push_data at the tail (ignored when full)
//   push_data  : entry to write
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry (undefined when empty)
//   count      : occupancy, 0..DEPTH
//   full       : count == DEPTH
// DEPTH must be a power of 2 (>= 2) so pointers wrap naturally.
module alsu_cmd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (count == FULL_CNT);
    do_push = push && !full;
    do_pop  = pop && (count != '0);
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alsu_logic_issue_stage.sv
// alsu_logic_issue_stage: sequential wrapper around the 4-bit logic unit.
//   clk, rst           : clock, synchronous active-high reset
//   In_Valid/In_Ready  : command handshake; In_Ready = (Count < DEPTH)
//   A, B, Sel          : command operands and operation select
//   Op_A, Op_B, Op_Sel : FIFO head driven to the logic unit (0 when empty)
//   Op_Out             : combinational logic-unit result
//   Out, Out_Sel       : registered result and the select that produced it
//   Out_Valid/Out_Ready: result handshake
//   Out_Zero           : registered (captured Op_Out == 0), only with
//                        ALSU_ZERO_FLAG_EN defined
//   Count              : FIFO occupancy, excluding the output slot
module alsu_logic_issue_stage
  import alsu_pkg::*;
#(
  parameter int DATA_W = ALSU_DATA_W,
  parameter int SEL_W  = ALSU_SEL_W,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  input  logic [DATA_W-1:0]       A,
  input  logic [DATA_W-1:0]       B,
  input  logic [SEL_W-1:0]        Sel,
  output logic [DATA_W-1:0]       Op_A,
  output logic [DATA_W-1:0]       Op_B,
  output logic [SEL_W-1:0]        Op_Sel,
  input  logic [DATA_W-1:0]       Op_Out,
  output logic [DATA_W-1:0]       Out,
  output logic [SEL_W-1:0]        Out_Sel,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
`ifdef ALSU_ZERO_FLAG_EN
  output logic                    Out_Zero,
`endif
  output logic [$clog2(DEPTH):0]  Count
);

  localparam int CMD_W = 2 * DATA_W + SEL_W;

  slot_state_t      state;
  logic [CMD_W-1:0] head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  alsu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({A, B, Sel}),
    .pop       (pop),
    .head      (head),
    .count     (Count),
    .full      (full)
  );

  always_comb begin
    empty    = (Count == '0);
    In_Ready = !full;
    push     = In_Valid && !full;
    // The slot takes a new head whenever it is empty or being drained.
    pop      = !empty && ((state == SLOT_IDLE) || Out_Ready);
    Op_A     = empty ? '0 : head[CMD_W-1 -: DATA_W];
    Op_B     = empty ? '0 : head[SEL_W +: DATA_W];
    Op_Sel   = empty ? '0 : head[SEL_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SLOT_IDLE;
      Out       <= '0;
      Out_Sel   <= '0;
      Out_Valid <= 1'b0;
`ifdef ALSU_ZERO_FLAG_EN
      Out_Zero  <= 1'b0;
`endif
    end else if (pop) begin
      state     <= SLOT_HOLD;
      Out       <= Op_Out;
      Out_Sel   <= Op_Sel;
      Out_Valid <= 1'b1;
`ifdef ALSU_ZERO_FLAG_EN
      Out_Zero  <= (Op_Out == '0);
`endif
    end else if ((state == SLOT_HOLD) && Out_Ready) begin
      state     <= SLOT_IDLE;
      Out_Valid <= 1'b0;
    end
  end

endmodule

// File: doc/alsu_logic_issue_stage.md
Name: alsu_logic_issue_stage

Overview:
- Sequential wrapper around the 4-bit AND/OR/XOR/XNOR logic unit.
- Input side: accepts {A, B, Sel} commands over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Operand side: drives the FIFO head onto the logic unit's operand/select inputs.
- Output side: captures the logic unit's combinational result into a registered, handshaked output slot.
- It is the stage feeding the logic unit and consuming its result, ahead of the ALSU output mux.

Parameters:
- DATA_W, 4: operand and result width.
- SEL_W, 2: operation select width.
- DEPTH, 4: command FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- In_Valid  in  1  command valid.
- In_Ready  out  1  command accept; equals (Count < DEPTH).
- A  in  DATA_W  operand A.
- B  in  DATA_W  operand B.
- Sel  in  SEL_W  operation select.
- Op_A  out  DATA_W  to logic unit A; FIFO head A, 0 when empty.
- Op_B  out  DATA_W  to logic unit B; FIFO head B, 0 when empty.
- Op_Sel  out  SEL_W  to logic unit Sel; FIFO head Sel, 0 when empty.
- Op_Out  in  DATA_W  result from logic unit (combinational in Op_A/Op_B/Op_Sel).
- Out  out  DATA_W  registered result.
- Out_Sel  out  SEL_W  Sel of the command that produced Out.
- Out_Valid  out  1  result valid.
- Out_Ready  in  1  downstream accept.
- Count  out  $clog2(DEPTH)+1  FIFO occupancy, excluding the output slot.

Behaviour:
- Reset: rst=1 at an edge clears Count, the read and write pointers, Out, Out_Sel and Out_Valid to 0.
  - FIFO storage contents are don't-care.
  - Reset mid-operation discards all buffered commands and any pending result; no partial drain.
- Push: occurs when In_Valid & In_Ready at an edge. The entry is written at wr_ptr and wr_ptr increments modulo DEPTH.
  - Full (Count==DEPTH): In_Ready=0. No push that cycle even if a pop occurs; no same-cycle full pass-through.
- Output slot FSM, two states:
  - IDLE (Out_Valid=0). If Count>0: pop the head, register Out<=Op_Out and Out_Sel<=Op_Sel, go to HOLD. Otherwise stay in IDLE.
  - HOLD (Out_Valid=1).
    - Out_Ready=0: Out and Out_Sel hold stable; no pop.
    - Out_Ready=1 and Count>0: pop and reload Out/Out_Sel with the new head; stay in HOLD. This gives full throughput of 1 result/cycle.
    - Out_Ready=1 and Count==0: go to IDLE, Out_Valid<=0. Out keeps its last value.
- Pop increments rd_ptr modulo DEPTH.
- Simultaneous push and pop: Count unchanged. Push into an empty FIFO is not visible to pop in the same cycle.
- Latency: command accepted at edge k → Out_Valid=1 with its result after edge k+1, when the slot is free.
- Ordering is strictly FIFO; results leave in acceptance order.
- Count: +1 on push-only, -1 on pop-only, never exceeds DEPTH or goes below 0.
- No arithmetic beyond pointer/counter wrap; pointer width is $clog2(DEPTH) and wraps naturally.

Optional Feature:
- Macro: ALSU_ZERO_FLAG_EN.
- Defined: adds output port Out_Zero (1 bit), registered with Out. It is 1 when the captured Op_Out==0, reset to 0, and holds with Out during a stall.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package alsu_pkg holds:
  - select encodings SEL_AND=2'b00, SEL_OR=2'b01, SEL_XOR=2'b10, SEL_XNOR=2'b11;
  - default DATA_W/SEL_W;
  - the command struct {A, B, Sel}.
- Sub-module: alsu_cmd_fifo, a parameterised synchronous FIFO with push/pop/Count/head.
- The output-slot FSM stays in the top.

Test Plan:
- rst, then A=4'b1100 B=4'b1010 Sel=00 for one cycle with Out_Ready=1 → Out=4'b1000, Out_Sel=00, Out_Valid high exactly one cycle starting after edge k+1; Count returns to 0.
- Back-to-back Sel=00,01,10,11 with the same operands, Out_Ready=1 → Out sequence 1000,1110,0110,1001 on consecutive cycles; In_Ready stays 1.
- Out_Ready=0, six commands offered → five accepted (one in the slot, Count=4), In_Ready=0, sixth held. Out_Ready=1 → all results drain in order, then the sixth is accepted.
- Stall: Out_Valid=1 with Out_Ready=0 for 3 cycles while the FIFO is non-empty → Out, Out_Sel and Count constant throughout.
- Count=2 and Out_Valid=1, assert rst for one cycle → Count=0, Out_Valid=0, Out=0. Next command A=4'b0011 B=4'b0101 Sel=10 → Out=4'b0110.
- ALSU_ZERO_FLAG_EN:
  - A=4'b0101 B=4'b1010 Sel=00 → Out=0000, Out_Zero=1.
  - Sel=01 → Out=1111, Out_Zero=0.
